// File: rtl/ssid_pkg.sv
// Shared widths, FSM state and FIFO entry layout for the SSID receiver.
package ssid_pkg;
  localparam int SSID_W = 8;
  localparam int X_W    = 4;
  localparam int Y_W    = 4;

  typedef enum logic {
    ACCEPT = 1'b0,
    DRAIN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           last;
  } entry_t;
endpackage

// File: rtl/ssid_fifo.sv
// Synchronous show-ahead FIFO: head entry is visible the cycle after its push and held until popped.
// Push is ignored when full, pop when empty; occupancy counter separates full from empty.
module ssid_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [7:0]
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  T                       i_wdat,
  input  logic                   i_pop,
  output T                       o_rdat,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Empty FIFO presents zeros so the decoded outputs have a defined idle value.
  always_comb begin
    o_rdat = '0;
    if (!o_empty) o_rdat = r_mem[r_rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/ssid_receiver.sv
// Per-layer SSID hit receiver: buffers words, splits x/y, counts hits per event; 1-cycle in->out latency,
// in_ready drops when full or while draining an event. Optional duplicate suppression via SSID_RX_DEDUP_EN.
module ssid_receiver
  import ssid_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [SSID_W-1:0] in_ssid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  output logic [X_W-1:0]    out_x,
  output logic [Y_W-1:0]    out_y,
  output logic              out_last,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  evt_hits,
  output logic              evt_done,
  output logic              overflow
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_t          r_state;
  logic [CNT_W-1:0] r_hit_count;
  logic [CNT_W-1:0] r_evt_hits;
  logic            r_evt_done;
  logic            r_overflow;

  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  entry_t          w_wdat;
  entry_t          w_rdat;
  logic            w_accept;
  logic            w_dup;
  logic            w_count_en;
  logic            w_pop;
  logic            w_drain_done;

  assign in_ready   = (r_state == ACCEPT) && !w_full;
  assign w_accept   = in_valid && in_ready;
  assign w_count_en = w_accept && !w_dup;
  assign w_pop      = out_valid && out_ready;

  assign w_wdat.x    = in_ssid[SSID_W-1 -: X_W];
  assign w_wdat.y    = in_ssid[Y_W-1:0];
  assign w_wdat.last = in_last;

  // Nothing is pushed while draining, so an empty FIFO (or popping its final entry) ends the event.
  assign w_drain_done = (r_state == DRAIN) && (w_empty || (w_pop && w_count == CW'(1)));

`ifdef SSID_RX_DEDUP_EN
  logic              r_prev_vld;
  logic [SSID_W-1:0] r_prev_ssid;

  // A repeated terminator must still be stored so the event end reaches downstream.
  assign w_dup = r_prev_vld && (in_ssid == r_prev_ssid) && !in_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_vld  <= 1'b0;
      r_prev_ssid <= '0;
    end else if (w_drain_done) begin
      r_prev_vld  <= 1'b0;
    end else if (w_accept) begin
      r_prev_vld  <= 1'b1;
      r_prev_ssid <= in_ssid;
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  ssid_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_count_en),
    .i_wdat  (w_wdat),
    .i_pop   (w_pop),
    .o_rdat  (w_rdat),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign out_valid = !w_empty;
  assign out_x     = w_rdat.x;
  assign out_y     = w_rdat.y;
  assign out_last  = w_rdat.last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ACCEPT;
      r_hit_count <= '0;
      r_evt_hits  <= '0;
      r_evt_done  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_evt_done <= 1'b0;
      case (r_state)
        ACCEPT: begin
          if (w_count_en) begin
            if (&r_hit_count) r_overflow  <= 1'b1;
            else              r_hit_count <= r_hit_count + 1'b1;
          end
          if (w_accept && in_last) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_drain_done) begin
            r_evt_done  <= 1'b1;
            r_evt_hits  <= r_hit_count;
            r_hit_count <= '0;
            r_state     <= ACCEPT;
          end
        end
        default: r_state <= ACCEPT;
      endcase
    end
  end

  assign hit_count = r_hit_count;
  assign evt_hits  = r_evt_hits;
  assign evt_done  = r_evt_done;
  assign overflow  = r_overflow;
endmodule

// File: tb/tb_ssid_receiver.sv
// Directed self-checking bench for ssid_receiver (DEPTH=8, CNT_W=8).
module tb_ssid_receiver;
  localparam int DEPTH = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [7:0]       in_ssid;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic [3:0]       out_x;
  logic [3:0]       out_y;
  logic             out_last;
  logic             out_ready;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] evt_hits;
  logic             evt_done;
  logic             overflow;

  int n_cmp  = 0;
  int n_err  = 0;
  int n_done = 0;
  logic [8:0] pop_q[$];

  always #5 clk = ~clk;

  ssid_receiver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ssid   (in_ssid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_last  (out_last),
    .out_ready (out_ready),
    .hit_count (hit_count),
    .evt_hits  (evt_hits),
    .evt_done  (evt_done),
    .overflow  (overflow)
  );

  // Record every popped entry as {x, y, last} == {ssid, last}, and count done pulses.
  always @(negedge clk) begin
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) pop_q.push_back({out_x, out_y, out_last});
    if (evt_done === 1'b1) n_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] s, input logic l);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1; in_ssid = s; in_last = l;
    for (int c = 0; c < 40 && !acc; c++) begin
      @(negedge clk);
      acc = (in_ready === 1'b1);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL send_word %h: in_ready=%b, required 1 within 40 cycles", s, in_ready);
    end
  endtask

  task automatic wait_done(output logic got);
    got = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (evt_done === 1'b1) begin got = 1'b1; break; end
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL wait_done: evt_done=%b, required 1 within 60 cycles", evt_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_ssid = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, out_last, evt_done, overflow, out_x, out_y, hit_count, evt_hits} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'd0, 8'd0}) begin
      n_err++;
      $display("FAIL reset_values: rdy=%b ov=%b ol=%b done=%b ovf=%b x=%h y=%h hc=%0d eh=%0d, required 1 0 0 0 0 0 0 0 0",
               in_ready, out_valid, out_last, evt_done, overflow, out_x, out_y, hit_count, evt_hits);
    end
    tick();
  endtask

  task automatic test_stream();
    logic got;
    logic [8:0] exp [4];
    exp = '{{8'h08, 1'b0}, {8'h38, 1'b0}, {8'h78, 1'b0}, {8'h88, 1'b1}};
    pop_q.delete(); out_ready = 1'b1;
    send_word(8'h08, 1'b0);
    n_cmp++;
    if ({out_valid, out_x, out_y, hit_count} !== {1'b1, 4'h0, 4'h8, 8'd1}) begin
      n_err++;
      $display("FAIL stream_latency: ov=%b x=%h y=%h hc=%0d, required 1 0 8 1", out_valid, out_x, out_y, hit_count);
    end
    send_word(8'h38, 1'b0);
    send_word(8'h78, 1'b0);
    send_word(8'h88, 1'b1);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_last, out_x, out_y, evt_done, hit_count, in_ready} !== {1'b1, 1'b1, 4'h8, 4'h8, 1'b0, 8'd4, 1'b0}) begin
      n_err++;
      $display("FAIL stream_last_head: ov=%b ol=%b x=%h y=%h done=%b hc=%0d rdy=%b, required 1 1 8 8 0 4 0",
               out_valid, out_last, out_x, out_y, evt_done, hit_count, in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if ({evt_done, evt_hits, hit_count, in_ready, out_valid} !== {1'b1, 8'd4, 8'd0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL stream_done: done=%b eh=%0d hc=%0d rdy=%b ov=%b, required 1 4 0 1 0",
               evt_done, evt_hits, hit_count, in_ready, out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (evt_done !== 1'b0) begin n_err++; $display("FAIL stream_done_pulse: evt_done=%b, required 0", evt_done); end
    n_cmp++;
    if (pop_q.size() != 4) begin n_err++; $display("FAIL stream_count: pops=%0d, required 4", pop_q.size()); end
    for (int i = 0; i < 4 && i < pop_q.size(); i++) begin
      n_cmp++;
      if (pop_q[i] !== exp[i]) begin n_err++; $display("FAIL stream_word%0d: got %h, required %h", i, pop_q[i], exp[i]); end
    end
    tick();
    got = 1'b0;
  endtask

  task automatic test_backpressure();
    logic acc;
    logic got;
    pop_q.delete(); out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_word(8'(8'h10 + i), 1'b0);
    in_valid = 1'b1; in_ssid = 8'h18; in_last = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, hit_count, out_x, out_y} !== {1'b0, 1'b1, 8'd8, 4'h1, 4'h0}) begin
      n_err++;
      $display("FAIL bp_full: rdy=%b ov=%b hc=%0d x=%h y=%h, required 0 1 8 1 0", in_ready, out_valid, hit_count, out_x, out_y);
    end
    tick();
    repeat (3) tick();
    @(negedge clk);
    n_cmp++;
    if ({in_ready, hit_count, out_x, out_y} !== {1'b0, 8'd8, 4'h1, 4'h0}) begin
      n_err++;
      $display("FAIL bp_hold: rdy=%b hc=%0d x=%h y=%h, required 0 8 1 0", in_ready, hit_count, out_x, out_y);
    end
    tick();
    out_ready = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 20 && !acc; c++) begin
      @(negedge clk);
      acc = (in_ready === 1'b1);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    n_cmp++;
    if (acc !== 1'b1) begin n_err++; $display("FAIL bp_ninth_accept: accepted=%b, required 1", acc); end
    wait_done(got);
    n_cmp++;
    if (evt_hits !== 8'd9) begin n_err++; $display("FAIL bp_evt_hits: evt_hits=%0d, required 9", evt_hits); end
    n_cmp++;
    if (pop_q.size() != 9) begin n_err++; $display("FAIL bp_count: pops=%0d, required 9", pop_q.size()); end
    for (int i = 0; i < 9 && i < pop_q.size(); i++) begin
      n_cmp++;
      if (pop_q[i] !== {8'(8'h10 + i), (i == 8)}) begin
        n_err++; $display("FAIL bp_order%0d: got %h, required %h", i, pop_q[i], {8'(8'h10 + i), (i == 8)});
      end
    end
    tick();
  endtask

  task automatic test_overflow();
    logic got;
    pop_q.delete(); out_ready = 1'b1;
    for (int i = 0; i < 255; i++) send_word(8'(i), 1'b0);
    n_cmp++;
    if ({hit_count, overflow} !== {8'd255, 1'b0}) begin
      n_err++; $display("FAIL ovf_at_max: hc=%0d ovf=%b, required 255 0", hit_count, overflow);
    end
    send_word(8'hFF, 1'b0);
    n_cmp++;
    if ({hit_count, overflow} !== {8'd255, 1'b1}) begin
      n_err++; $display("FAIL ovf_saturate: hc=%0d ovf=%b, required 255 1", hit_count, overflow);
    end
    for (int i = 256; i < 299; i++) send_word(8'(i), 1'b0);
    send_word(8'(299), 1'b1);
    wait_done(got);
    n_cmp++;
    if ({evt_hits, overflow, hit_count} !== {8'd255, 1'b1, 8'd0}) begin
      n_err++; $display("FAIL ovf_evt: eh=%0d ovf=%b hc=%0d, required 255 1 0", evt_hits, overflow, hit_count);
    end
    n_cmp++;
    if (pop_q.size() != 300) begin n_err++; $display("FAIL ovf_pops: pops=%0d, required 300", pop_q.size()); end
    tick();
    send_word(8'h01, 1'b0);
    send_word(8'h02, 1'b1);
    wait_done(got);
    n_cmp++;
    if ({evt_hits, overflow} !== {8'd2, 1'b1}) begin
      n_err++; $display("FAIL ovf_sticky: eh=%0d ovf=%b, required 2 1", evt_hits, overflow);
    end
    tick();
  endtask

  task automatic test_midreset();
    logic got;
    int d0;
    pop_q.delete(); out_ready = 1'b0; d0 = n_done;
    send_word(8'h61, 1'b0);
    send_word(8'h62, 1'b0);
    send_word(8'h63, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, hit_count, in_ready, evt_done, overflow} !== {1'b0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL rst_flush: ov=%b hc=%0d rdy=%b done=%b ovf=%b, required 0 0 1 0 0", out_valid, hit_count, in_ready, evt_done, overflow);
    end
    tick();
    repeat (3) tick();
    n_cmp++;
    if (n_done != d0) begin n_err++; $display("FAIL rst_no_done: pulses=%0d, required 0", n_done - d0); end
    out_ready = 1'b1;
    send_word(8'h21, 1'b0);
    n_cmp++;
    if (hit_count !== 8'd1) begin n_err++; $display("FAIL rst_fresh_count: hc=%0d, required 1", hit_count); end
    send_word(8'h22, 1'b1);
    wait_done(got);
    n_cmp++;
    if (evt_hits !== 8'd2) begin n_err++; $display("FAIL rst_fresh_evt: eh=%0d, required 2", evt_hits); end
    n_cmp++;
    if (pop_q.size() != 2) begin n_err++; $display("FAIL rst_stale: pops=%0d, required 2", pop_q.size()); end
    tick();
    send_word(8'h9A, 1'b1);
    wait_done(got);
    n_cmp++;
    if (evt_hits !== 8'd1) begin n_err++; $display("FAIL single_hit: eh=%0d, required 1", evt_hits); end
    tick();
  endtask

  task automatic test_drain_hold();
    logic got;
    logic got2;
    pop_q.delete(); out_ready = 1'b0;
    send_word(8'h31, 1'b0);
    send_word(8'h32, 1'b1);
    in_valid = 1'b1; in_ssid = 8'h41; in_last = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL drain_blocked%0d: in_ready=%b, required 0", c, in_ready); end
      tick();
    end
    out_ready = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      n_cmp++;
      if (evt_done === 1'b1) begin
        got = 1'b1;
        if ({in_ready, hit_count, evt_hits} !== {1'b1, 8'd0, 8'd2}) begin
          n_err++; $display("FAIL drain_release: rdy=%b hc=%0d eh=%0d, required 1 0 2", in_ready, hit_count, evt_hits);
        end
      end else if (in_ready !== 1'b0) begin
        n_err++; $display("FAIL drain_early_ready: in_ready=%b, required 0", in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (got !== 1'b1) begin n_err++; $display("FAIL drain_done_seen: got=%b, required 1", got); end
    n_cmp++;
    if ({hit_count, out_valid, out_x, out_y} !== {8'd1, 1'b1, 4'h4, 4'h1}) begin
      n_err++; $display("FAIL drain_held_word: hc=%0d ov=%b x=%h y=%h, required 1 1 4 1", hit_count, out_valid, out_x, out_y);
    end
    send_word(8'h42, 1'b1);
    wait_done(got2);
    n_cmp++;
    if (evt_hits !== 8'd2) begin n_err++; $display("FAIL drain_next_evt: eh=%0d, required 2", evt_hits); end
    tick();
  endtask

  task automatic test_dedup();
    logic got;
    logic [8:0] exp [$];
    logic [CNT_W-1:0] exp_hits;
`ifdef SSID_RX_DEDUP_EN
    exp = '{{8'h55, 1'b0}, {8'h56, 1'b0}, {8'h56, 1'b1}};
    exp_hits = 8'd3;
`else
    exp = '{{8'h55, 1'b0}, {8'h55, 1'b0}, {8'h56, 1'b0}, {8'h56, 1'b1}};
    exp_hits = 8'd4;
`endif
    pop_q.delete(); out_ready = 1'b1;
    send_word(8'h55, 1'b0);
    send_word(8'h55, 1'b0);
    send_word(8'h56, 1'b0);
    send_word(8'h56, 1'b1);
    wait_done(got);
    n_cmp++;
    if (evt_hits !== exp_hits) begin n_err++; $display("FAIL dedup_hits: eh=%0d, required %0d", evt_hits, exp_hits); end
    n_cmp++;
    if (pop_q.size() != exp.size()) begin n_err++; $display("FAIL dedup_count: pops=%0d, required %0d", pop_q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < pop_q.size(); i++) begin
      n_cmp++;
      if (pop_q[i] !== exp[i]) begin n_err++; $display("FAIL dedup_word%0d: got %h, required %h", i, pop_q[i], exp[i]); end
    end
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_overflow();
    test_midreset();
    test_drain_hold();
    test_dedup();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ssid_receiver.md
# ssid_receiver

Consumer end of the SSID hit stream: accepts 8-bit SSID words from the hit source over a valid/ready handshake and buffers them in a small FIFO. It decodes each word into x/y strip positions for the downstream pattern-matching logic and keeps per-event hit counts. It sits between the SSID generator/counter front end and the pattern-match stage, one instance per layer.

## Interface
- DEPTH, 8, FIFO entries (power of two, ≥2)
- CNT_W, 8, width of hit counters
- clk  input  1  rising-edge clock, sole clock domain
- reset  input  1  synchronous, active-high; sampled on posedge clk
- in_valid  input  1  source has an SSID word
- in_ssid  input  8  SSID word, {x[3:0], y[3:0]}
- in_last  input  1  word is the final hit of the event
- in_ready  output  1  receiver accepts the word this cycle
- out_valid  output  1  decoded hit available
- out_x  output  4  x position (in_ssid[7:4])
- out_y  output  4  y position (in_ssid[3:0])
- out_last  output  1  hit closes the event
- out_ready  input  1  downstream consumes the hit this cycle
- hit_count  output  CNT_W  hits accepted so far in the current event, saturating
- evt_hits  output  CNT_W  final hit_count of the last completed event
- evt_done  output  1  one-cycle pulse when an event has fully drained
- overflow  output  1  sticky; hit_count saturated at some point since reset

## Operation
- States: ACCEPT, DRAIN.
- ACCEPT: in_ready = !full. Accept = in_valid && in_ready. Each accepted word is written as {x, y, last} and hit_count increments, saturating at 2^CNT_W−1. An increment attempted at saturation sets overflow.
- Accepting a word with in_last=1 moves the FSM to DRAIN.
- DRAIN: in_ready = 0. Wait until the FIFO is empty and no entry is in flight. Then:
  - evt_done pulses for 1 cycle.
  - evt_hits ← hit_count.
  - hit_count ← 0.
  - FSM returns to ACCEPT.
- Output side is show-ahead: out_valid = !empty, and out_x/out_y/out_last show the head entry. A pop occurs when out_valid && out_ready.
- Push and pop in the same cycle are both honoured (count unchanged). Since in_ready depends only on full, a push is never granted while the FIFO is full.
- The data outputs hold their value while out_valid && !out_ready (AXI-style stability).
- No decoding arithmetic: x/y are a pure bit split of the stored word.

## Timing
- Reset values:
  - in_ready = 1 (ACCEPT, empty)
  - out_valid, out_last, evt_done, overflow = 0
  - out_x, out_y, hit_count, evt_hits = 0
- Latency: a word accepted at cycle N is visible on the outputs at cycle N+1.
- Throughput: 1 word/cycle sustained in both directions when out_ready=1.
- evt_done asserts on the cycle after the pop of the out_last entry. evt_hits and the cleared hit_count are visible that same cycle. The earliest next accept is that same cycle.
- A single-hit event (in_last on the first word) yields evt_hits=1.
- Reset mid-event flushes the FIFO, returns to ACCEPT, and clears all counters and overflow. There is no evt_done pulse.
- Pointers wrap modulo DEPTH. A separate occupancy counter (0..DEPTH) distinguishes full from empty.

## Configuration
- SSID_RX_DEDUP_EN defined:
  - An accepted word equal to the previous accepted SSID of the same event is consumed (handshake completes) but neither written nor counted.
  - A duplicate carrying in_last is written and counted normally, so the event terminator always propagates.
  - The previous-SSID register is invalidated at reset and at event end.
- SSID_RX_DEDUP_EN undefined: every accepted word is written and counted, and the comparison logic is absent.

## Structure
- Shared package ssid_pkg holds:
  - SSID_W=8, X_W=4, Y_W=4
  - the state enum {ACCEPT, DRAIN}
  - the FIFO entry typedef {x, y, last}
- One sub-module: ssid_fifo, a synchronous show-ahead FIFO parameterised on DEPTH and entry type, with full/empty/count.
- FSM, counters and dedup logic live in ssid_receiver.

## Test plan
- Stream 0x08,0x38,0x78,0x88(last), out_ready=1 -> outputs x/y = 0/8, 3/8, 7/8, 8/8; out_last on the 4th; evt_done 1 cycle after; evt_hits=4, hit_count=0.
- out_ready=0 while 9 words are offered, DEPTH=8 -> in_ready drops after 8 accepts; the 9th is held; raising out_ready drains in order with no loss.
- Event of 300 hits, CNT_W=8 -> hit_count sticks at 255; overflow=1 and stays set through the next event; evt_hits=255.
- Assert reset after 3 of 5 words accepted -> next cycle out_valid=0, hit_count=0, in_ready=1, no evt_done; a fresh event then counts from 1.
- Words offered during DRAIN (in_valid held high) -> in_ready=0 until evt_done; the held word is accepted on the evt_done cycle and counted in the new event.
- With SSID_RX_DEDUP_EN: 0x55,0x55,0x56,0x56(last) -> outputs 0x55, 0x56, 0x56(last); evt_hits=3. Without the macro: 4 outputs; evt_hits=4.
